// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings and nibble width.
package nibble_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// 4-bit ripple-carry adder, the single arithmetic resource reused every RUN cycle.
module RippleCarryAdder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);

   logic [4:0] c;

   // Chain of full adders, carry rippling from bit 0 upward.
   always_comb begin
      c[0] = c_in;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
      c_out = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serialises a WIDTH-bit addition onto one 4-bit adder, LSB nibble first,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
         $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   // Two's-complement overflow from operand and result sign bits.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic             a_msb, b_msb;
   logic             accept;
   logic [3:0]       nib;
   logic             nib_c;

   assign accept = in_valid && in_ready;

   RippleCarryAdder_4bit u_rca (
      .a     (a_sh[3:0]),
      .b     (b_sh[3:0]),
      .c_in  (carry),
      .sum   (nib),
      .c_out (nib_c)
   );

   // Control state: FSM, nibble index and running carry; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx   <= '0;
         carry <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            idx   <= '0;
            carry <= c_in;
         end else if (state == S_RUN) begin
            idx   <= idx + 1'b1;
            carry <= nib_c;
         end
      end
   end

   // Datapath: operand shift-out and sum shift-in; gated at the outputs so left unreset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh  <= in1;
         b_sh  <= in2;
         a_msb <= in1[WIDTH-1];
         b_msb <= in2[WIDTH-1];
      end else if (state == S_RUN) begin
         a_sh   <= a_sh >> NIBBLE_W;
         b_sh   <= b_sh >> NIBBLE_W;
         // New nibble enters at the top so the LSB nibble ends up at bit 0 after NIBBLES steps.
         sum_sh <= WIDTH'({nib, sum_sh} >> NIBBLE_W);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)         state_nxt = S_RUN;
         S_RUN:   if (idx == LAST_IDX)  state_nxt = S_DONE;
         S_DONE:  if (out_ready)        state_nxt = S_IDLE;
         default:                       state_nxt = S_IDLE;
      endcase
   end

   // Handshake and gated result outputs: results are visible only in DONE.
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      sum       = out_valid ? sum_sh : '0;
      c_out     = out_valid ? carry : 1'b0;
      ovf       = out_valid ? add_ovf(a_msb, b_msb, sum_sh[WIDTH-1]) : 1'b0;
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed vector bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

   localparam int W = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in1, in2;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[9];

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One transaction; hold=1 keeps out_ready low for 5 DONE cycles while pulsing in_valid.
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic eco, input logic eov, input bit hold);
      int lat;
      int wait_cyc;
      logic [W-1:0] held_sum;
      @(negedge clk);
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      out_ready = !hold;
      in_valid  = 1'b1;
      in1 = a; in2 = b; c_in = ci;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in1 = ~a; in2 = ~b; c_in = ~ci;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (!out_valid) chk("sum_gated_in_run", {16'd0, sum}, 32'd0);
      end while (!out_valid && lat < 40);
      chk("latency", lat, NIB);
      chk("sum", {16'd0, sum}, {16'd0, es});
      chk("c_out", {31'd0, c_out}, {31'd0, eco});
      chk("ovf", {31'd0, ovf}, {31'd0, eov});
      chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      if (hold) begin
         held_sum = sum;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in1 = 16'hAAAA; in2 = 16'h5555; c_in = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, held_sum});
            chk("hold_cout_ovf", {30'd0, c_out, ovf}, {30'd0, eco, eov});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("idle_after_done_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_after_done_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [W:0] full;
      logic [W-1:0] ra, rb;
      logic rc, rov;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[5] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; c_in = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_outputs", {14'd0, sum, c_out, ovf}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_txn(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);

      // Backpressure in DONE, then confirm the ignored pulses left no trace.
      run_txn(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      run_txn(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

      // Reset at RUN index 2 discards the partial result.
      @(negedge clk);
      in_valid = 1'b1; in1 = 16'hFFFF; in2 = 16'hFFFF; c_in = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrun_reset_valid", {31'd0, out_valid}, 32'd0);
      chk("midrun_reset_sum", {16'd0, sum}, 32'd0);
      chk("midrun_reset_ready", {31'd0, in_ready}, 32'd1);
      repeat (6) begin
         @(posedge clk);
         #1;
         chk("midrun_no_emit", {31'd0, out_valid}, 32'd0);
      end
      run_txn(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

      // Random vectors against a behavioural sum.
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         rov = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
         run_txn(ra, rb, rc, full[W-1:0], full[W], rov, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
